// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: memory request/response, redirect and decode handshake signals.
// The master modport is the fetch unit; the slave modport is the surrounding core/memory.
interface instruction_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] o_Instruction_Addr;
    logic [XLEN-1:0] i_Instruction;
    logic            i_Instruction_Valid;
    logic            i_Redirect;
    logic [XLEN-1:0] i_Redirect_PC;
    logic            o_Fetch_Valid;
    logic [XLEN-1:0] o_Fetch_Instruction;
    logic [XLEN-1:0] o_Fetch_PC;
    logic            i_Decode_Ready;
    logic            o_Fetch_Misaligned;

    modport master (
        output o_Instruction_Addr,
        input  i_Instruction,
        input  i_Instruction_Valid,
        input  i_Redirect,
        input  i_Redirect_PC,
        output o_Fetch_Valid,
        output o_Fetch_Instruction,
        output o_Fetch_PC,
        input  i_Decode_Ready,
        output o_Fetch_Misaligned
    );

    modport slave (
        input  o_Instruction_Addr,
        output i_Instruction,
        output i_Instruction_Valid,
        output i_Redirect,
        output i_Redirect_PC,
        input  o_Fetch_Valid,
        input  o_Fetch_Instruction,
        input  o_Fetch_PC,
        output i_Decode_Ready,
        input  o_Fetch_Misaligned
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC generator plus PC-tagged fetch FIFO feeding decode, with redirect flush and stale-fetch discard.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirects raise a sticky flag and stall fetch.
module instruction_fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input logic                      i_Clock,
    input logic                      i_Reset,
    instruction_fetch_unit_if.master fetch_bus
);
    localparam int unsigned    PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             discard_q, discard_d;
    logic             misaligned_q;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [XLEN-1:0]  fifo_pc    [FIFO_DEPTH];
    logic [XLEN-1:0]  fifo_instr [FIFO_DEPTH];
    logic [XLEN-1:0]  redirect_pc;
    logic             empty, full, pop, push;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_pc = fetch_bus.i_Redirect_PC;

    // Sticky until the next redirect re-evaluates alignment.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            misaligned_q <= 1'b0;
        end else if (fetch_bus.i_Redirect) begin
            misaligned_q <= (fetch_bus.i_Redirect_PC[1:0] != 2'b00);
        end
    end
`else
    assign redirect_pc  = fetch_bus.i_Redirect_PC & ~XLEN'(3);
    assign misaligned_q = 1'b0;
`endif

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == FULL_COUNT);
        pop       = !empty && fetch_bus.i_Decode_Ready && !fetch_bus.i_Redirect;
        push      = fetch_bus.i_Instruction_Valid && !discard_q && !misaligned_q &&
                    !fetch_bus.i_Redirect && (!full || pop);
        pc_d      = pc_q;
        discard_d = discard_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (fetch_bus.i_Redirect) begin
            // A response arriving with the redirect is the stale one; otherwise one is still owed.
            pc_d      = redirect_pc;
            discard_d = discard_q | ~fetch_bus.i_Instruction_Valid;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
        end else begin
            if (fetch_bus.i_Instruction_Valid && discard_q && !misaligned_q) begin
                discard_d = 1'b0;
            end
            if (push) begin
                pc_d     = pc_q + XLEN'(4);
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            discard_q <= discard_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: the head outputs are masked while empty.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            fifo_pc[wr_ptr_q]    <= pc_q;
            fifo_instr[wr_ptr_q] <= fetch_bus.i_Instruction;
        end
    end

    assign fetch_bus.o_Instruction_Addr  = pc_q;
    assign fetch_bus.o_Fetch_Valid       = !empty;
    assign fetch_bus.o_Fetch_Instruction = empty ? '0 : fifo_instr[rd_ptr_q];
    assign fetch_bus.o_Fetch_PC          = empty ? '0 : fifo_pc[rd_ptr_q];
    assign fetch_bus.o_Fetch_Misaligned  = misaligned_q;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
PC generator and fetch buffer sitting directly upstream of instruction_memory_axi. It drives the memory's instruction address and captures each instruction-valid pulse. Captured words are pushed, tagged with their PC, into a 2-entry FIFO that feeds decode over a valid/ready handshake. It handles decode backpressure and branch/jump redirects, including discarding stale in-flight fetches.

Parameters:
XLEN, 32, data/address width (from cpu_core_params.vh)
RESET_PC, 32'h0000_0000, PC loaded on reset
FIFO_DEPTH, 2, fetch buffer entries; power of two, min 2

Ports:
i_Clock  in  1  clock
i_Reset  in  1  async active-high reset
o_Instruction_Addr  out  XLEN  current PC to instruction memory
i_Instruction  in  XLEN  instruction word from memory
i_Instruction_Valid  in  1  one-cycle pulse, memory response for o_Instruction_Addr
i_Redirect  in  1  taken branch/jump/trap; flush and reload PC
i_Redirect_PC  in  XLEN  new PC when i_Redirect=1
o_Fetch_Valid  out  1  FIFO head valid
o_Fetch_Instruction  out  XLEN  FIFO head instruction
o_Fetch_PC  out  XLEN  FIFO head PC
i_Decode_Ready  in  1  decode consumes head when o_Fetch_Valid && i_Decode_Ready
o_Fetch_Misaligned  out  1  see Optional Feature; tied 0 when feature is compiled out

Behaviour:
- Reset (async): PC=RESET_PC, FIFO empty, discard flag=0, o_Fetch_Valid=0, o_Fetch_Instruction=0, o_Fetch_PC=0, o_Fetch_Misaligned=0.
- The memory self-issues reads continuously. o_Instruction_Addr=PC (registered), changes only on an accept edge or a redirect edge.
- Accept: i_Instruction_Valid && !discard && !i_Redirect && (FIFO not full || pop this cycle).
  - On accept: push {PC, i_Instruction}; PC<=PC+4 (mod 2^XLEN, wraps silently).
- Drop on full: valid pulse with FIFO full and no pop -> word dropped, PC unchanged. The memory refetches the same address; no instruction is lost or duplicated.
- Discard flag:
  - Redirect without a coincident valid pulse: PC<=i_Redirect_PC, FIFO flushed, discard<=1.
  - Next valid pulse while discard=1 is dropped, discard<=0, PC unchanged.
  - This drop is conservative: it may waste one fetch, never returns a stale word.
- Redirect coincident with a valid pulse: the pulse is dropped, PC<=i_Redirect_PC, FIFO flushed, discard stays 0.
- Redirect while discard=1: PC updated, FIFO flushed, discard remains 1.
- Redirect has priority over push and pop in the same cycle. A decode pop that cycle is lost (decode is being flushed anyway).
- FIFO:
  - Push and pop in the same cycle when full: both occur, count unchanged.
  - Outputs o_Fetch_* reflect the head combinationally from FIFO registers; zero when empty.
  - Order strictly preserved.
- Latency: with memory at 4-cycle cadence and no stalls, first o_Fetch_Valid appears the cycle after the first accept edge. Steady throughput is one instruction per memory response.

Optional Feature:
Macro FETCH_MISALIGN_CHECK_EN.
- Defined: redirect with i_Redirect_PC[1:0]!=0 sets o_Fetch_Misaligned=1 (sticky) and loads the PC unmodified. All valid pulses are dropped and nothing is pushed.
  - Cleared by an aligned redirect (flag<=0, normal discard rules apply) or by reset.
- Undefined: i_Redirect_PC[1:0] is forced to 2'b00 on load; o_Fetch_Misaligned tied 0.

Test Plan:
- Reset, RESET_PC=0, memory preloaded with 0x13,0x93,... and i_Decode_Ready=1 -> o_Fetch_PC sequence 0,4,8,12 with matching words; o_Instruction_Addr never changes except on accept edges.
- i_Decode_Ready=0 for 20 cycles -> FIFO holds PC 0,4; further pulses dropped; PC stays 8. Release -> PCs 0,4,8,12 delivered, no gap or duplicate.
- Redirect to 0x100 one cycle after an accept edge (memory mid-transaction) -> FIFO empties same edge; next valid pulse discarded; next o_Fetch_PC=0x100 with mem[0x100].
- Redirect to 0x200 coincident with a valid pulse -> pulse dropped, discard stays 0, next accepted word is mem[0x200] with PC 0x200.
- PC wrap: RESET_PC=32'hFFFF_FFFC -> PCs FFFF_FFFC, then 0000_0000.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> o_Fetch_Misaligned=1, o_Fetch_Valid stays 0. Redirect to 0x104 -> flag clears, fetch resumes at 0x104. Without the macro, redirect to 0x102 -> fetch from 0x100.
